// File: rtl/present_wb_pkg.sv
// Shared definitions for the PRESENT-80 Wishbone initiator: register map,
// CONTROL_0 bit layout and state encodings.
package present_wb_pkg;

  localparam logic [31:0] OFF_KEY_0      = 32'd0;
  localparam logic [31:0] OFF_KEY_1      = 32'd4;
  localparam logic [31:0] OFF_PLAIN_0    = 32'd8;
  localparam logic [31:0] OFF_PLAIN_1    = 32'd12;
  localparam logic [31:0] OFF_CMOS_OUT_0 = 32'd16;
  localparam logic [31:0] OFF_CMOS_OUT_1 = 32'd20;
  localparam logic [31:0] OFF_CONTROL_0  = 32'd24;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_DONE_BIT  = 8;
  localparam int CTRL_KEYHI_LSB = 16;
  localparam int CTRL_KEYHI_MSB = 31;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_KEY0,
    S_W_KEY1,
    S_W_PL0,
    S_W_PL1,
    S_W_CTRL,
    S_R_POLL,
    S_R_OUT0,
    S_R_OUT1,
    S_RESP
  } seq_state_t;

  typedef enum logic [1:0] {
    X_IDLE,
    X_REQ,
    X_GAP
  } xfer_phase_t;

  // CONTROL_0 write word: top 16 key bits plus the start bit.
  function automatic logic [31:0] ctrl_start_word(input logic [15:0] key_hi);
    logic [31:0] w;
    w = '0;
    w[CTRL_KEYHI_MSB:CTRL_KEYHI_LSB] = key_hi;
    w[CTRL_START_BIT] = 1'b1;
    return w;
  endfunction

  // Register offset touched by each bus state.
  function automatic logic [31:0] state_offset(input seq_state_t s);
    case (s)
      S_W_KEY0: return OFF_KEY_0;
      S_W_KEY1: return OFF_KEY_1;
      S_W_PL0:  return OFF_PLAIN_0;
      S_W_PL1:  return OFF_PLAIN_1;
      S_W_CTRL: return OFF_CONTROL_0;
      S_R_POLL: return OFF_CONTROL_0;
      S_R_OUT0: return OFF_CMOS_OUT_0;
      S_R_OUT1: return OFF_CMOS_OUT_1;
      default:  return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/present_wb_xfer.sv
// Single Wishbone classic transfer engine: REQ phase until ack or timeout,
// then one GAP cycle during which the result is presented to the sequencer.
//
// phase  | meaning
// X_IDLE | bus idle, waiting for start
// X_REQ  | cyc/stb high, waiting for ack, ack timer running
// X_GAP  | cyc/stb low for one cycle; done pulse, err/rdata valid
module present_wb_xfer
  import present_wb_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] req_adr,
  input  logic        req_we,
  input  logic [31:0] req_dat,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int TW = $clog2(ACK_TIMEOUT);

  xfer_phase_t   phase_q, phase_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  // Phase register and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= X_IDLE;
      tmr_q   <= '0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      phase_q <= phase_d;
      tmr_q   <= tmr_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Next phase: launch on start, finish on ack or ack-timer terminal count.
  always_comb begin
    phase_d = phase_q;
    tmr_d   = tmr_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (phase_q)
      X_IDLE, X_GAP: begin
        if (start) begin
          phase_d = X_REQ;
          stb_d   = 1'b1;
          we_d    = req_we;
          adr_d   = req_adr;
          dat_d   = req_we ? req_dat : 32'd0;
          tmr_d   = TW'(ACK_TIMEOUT - 1);
          err_d   = 1'b0;
        end else begin
          phase_d = X_IDLE;
        end
      end
      X_REQ: begin
        if (wbm_ack_i || tmr_q == '0) begin
          phase_d = X_GAP;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          adr_d   = '0;
          dat_d   = '0;
          tmr_d   = '0;
          if (wbm_ack_i) rdata_d = wbm_dat_i;
          else           err_d   = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: phase_d = X_IDLE;
    endcase
  end

  assign wbm_cyc_o = stb_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = {4{stb_q}};
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign done      = (phase_q == X_GAP);
  assign err       = err_q;
  assign rdata     = rdata_q;

endmodule

// File: rtl/present_wb_initiator.sv
// Wishbone initiator that runs one PRESENT-80 encryption on the register
// slave: write key/plain/control, poll for done, read the ciphertext back.
//
// state    | meaning
// S_IDLE   | ready for a command
// S_W_KEY0 | write KEY_0 = key[31:0]
// S_W_KEY1 | write KEY_1 = key[63:32]
// S_W_PL0  | write PLAIN_0 = plain[31:0]
// S_W_PL1  | write PLAIN_1 = plain[63:32]
// S_W_CTRL | write CONTROL_0 = {key[79:64], start}
// S_R_POLL | read CONTROL_0 until done or poll limit
// S_R_OUT0 | read CMOS_OUT_0 -> cipher[31:0]
// S_R_OUT1 | read CMOS_OUT_1 -> cipher[63:32]
// S_RESP   | hold response until rsp_ready_i
module present_wb_initiator
  import present_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h0300_0000,
  parameter int          ACK_TIMEOUT  = 16,
  parameter int          POLL_MAX     = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [79:0] cmd_key_i,
  input  logic [63:0] cmd_plain_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_cipher_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy_o
);

  localparam int PW = $clog2(POLL_MAX + 1);

  seq_state_t    state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [79:0]   key_q, key_d;
  logic [63:0]   plain_q, plain_d;
  logic [63:0]   cipher_q, cipher_d;
  logic          err_q, err_d;

  logic          x_start;
  logic [31:0]   x_adr;
  logic          x_we;
  logic [31:0]   x_dat;
  logic          x_done;
  logic          x_err;
  logic [31:0]   x_rdata;

  // Sequencer state and latched command/response registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      poll_q   <= '0;
      key_q    <= '0;
      plain_q  <= '0;
      cipher_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      poll_q   <= poll_d;
      key_q    <= key_d;
      plain_q  <= plain_d;
      cipher_q <= cipher_d;
      err_q    <= err_d;
    end
  end

  // Next state; a transfer is launched in the same cycle the state advances
  // so the engine goes straight from GAP into the next REQ.
  always_comb begin
    state_d  = state_q;
    poll_d   = poll_q;
    key_d    = key_q;
    plain_d  = plain_q;
    cipher_d = cipher_q;
    err_d    = err_q;
    x_start  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          state_d  = S_W_KEY0;
          key_d    = cmd_key_i;
          plain_d  = cmd_plain_i;
          cipher_d = '0;
          err_d    = 1'b0;
          poll_d   = '0;
          x_start  = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: begin
        if (x_done) begin
          if (x_err) begin
            state_d  = S_RESP;
            err_d    = 1'b1;
            cipher_d = '0;
          end else begin
            case (state_q)
              S_W_KEY0: begin state_d = S_W_KEY1; x_start = 1'b1; end
              S_W_KEY1: begin state_d = S_W_PL0;  x_start = 1'b1; end
              S_W_PL0:  begin state_d = S_W_PL1;  x_start = 1'b1; end
              S_W_PL1:  begin state_d = S_W_CTRL; x_start = 1'b1; end
              S_W_CTRL: begin state_d = S_R_POLL; x_start = 1'b1; end
              S_R_POLL: begin
                if (x_rdata[CTRL_DONE_BIT]) begin
                  state_d = S_R_OUT0;
                  x_start = 1'b1;
                end else if (poll_q >= PW'(POLL_MAX - 1)) begin
                  state_d  = S_RESP;
                  err_d    = 1'b1;
                  cipher_d = '0;
                end else begin
                  poll_d  = poll_q + 1'b1;
                  x_start = 1'b1;
                end
              end
              S_R_OUT0: begin
                cipher_d[31:0] = x_rdata;
                state_d        = S_R_OUT1;
                x_start        = 1'b1;
              end
              S_R_OUT1: begin
                cipher_d[63:32] = x_rdata;
                state_d         = S_RESP;
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  // Request fields for the transfer belonging to the state being entered.
  always_comb begin
    x_adr = BASE_ADDRESS + state_offset(state_d);
    x_we  = 1'b0;
    x_dat = '0;
    case (state_d)
      S_W_KEY0: begin x_we = 1'b1; x_dat = key_d[31:0];   end
      S_W_KEY1: begin x_we = 1'b1; x_dat = key_d[63:32];  end
      S_W_PL0:  begin x_we = 1'b1; x_dat = plain_d[31:0]; end
      S_W_PL1:  begin x_we = 1'b1; x_dat = plain_d[63:32]; end
      S_W_CTRL: begin x_we = 1'b1; x_dat = ctrl_start_word(key_d[79:64]); end
      default:  begin x_we = 1'b0; x_dat = '0; end
    endcase
  end

  present_wb_xfer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_xfer (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .start     (x_start),
    .req_adr   (x_adr),
    .req_we    (x_we),
    .req_dat   (x_dat),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .done      (x_done),
    .err       (x_err),
    .rdata     (x_rdata)
  );

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign rsp_valid_o  = (state_q == S_RESP);
  assign rsp_cipher_o = cipher_q;
  assign rsp_err_o    = err_q;

endmodule

// File: tb/tb_present_wb_initiator.sv
// Bench for present_wb_initiator: two instances (default poll limit and a
// poll limit of 3) share one registered-ack slave model; each command is
// checked against an expected transfer list, latency and response.
module tb_present_wb_initiator;

  localparam logic [31:0] BASE = 32'h0300_0000;
  localparam int          T    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid;
  logic [79:0] cmd_key;
  logic [63:0] cmd_plain;
  logic        rsp_ready;
  bit          sel_b;

  logic        a_cmd_ready, a_rsp_valid, a_rsp_err, a_cyc, a_stb, a_we, a_busy, a_ack;
  logic [63:0] a_cipher;
  logic [3:0]  a_sel;
  logic [31:0] a_adr, a_dat;
  logic        b_cmd_ready, b_rsp_valid, b_rsp_err, b_cyc, b_stb, b_we, b_busy, b_ack;
  logic [63:0] b_cipher;
  logic [3:0]  b_sel;
  logic [31:0] b_adr, b_dat;

  logic        s_ack;
  logic [31:0] s_dat;

  present_wb_initiator #(.BASE_ADDRESS(BASE), .ACK_TIMEOUT(T), .POLL_MAX(255)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid & ~sel_b), .cmd_ready_o(a_cmd_ready),
    .cmd_key_i(cmd_key), .cmd_plain_i(cmd_plain),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(rsp_ready & ~sel_b),
    .rsp_cipher_o(a_cipher), .rsp_err_o(a_rsp_err),
    .wbm_cyc_o(a_cyc), .wbm_stb_o(a_stb), .wbm_we_o(a_we), .wbm_sel_o(a_sel),
    .wbm_adr_o(a_adr), .wbm_dat_o(a_dat), .wbm_dat_i(s_dat), .wbm_ack_i(a_ack),
    .busy_o(a_busy));

  present_wb_initiator #(.BASE_ADDRESS(BASE), .ACK_TIMEOUT(T), .POLL_MAX(3)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid & sel_b), .cmd_ready_o(b_cmd_ready),
    .cmd_key_i(cmd_key), .cmd_plain_i(cmd_plain),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready & sel_b),
    .rsp_cipher_o(b_cipher), .rsp_err_o(b_rsp_err),
    .wbm_cyc_o(b_cyc), .wbm_stb_o(b_stb), .wbm_we_o(b_we), .wbm_sel_o(b_sel),
    .wbm_adr_o(b_adr), .wbm_dat_o(b_dat), .wbm_dat_i(s_dat), .wbm_ack_i(b_ack),
    .busy_o(b_busy));

  assign a_ack = s_ack & ~sel_b;
  assign b_ack = s_ack & sel_b;

  wire        m_cyc       = sel_b ? b_cyc       : a_cyc;
  wire        m_stb       = sel_b ? b_stb       : a_stb;
  wire        m_we        = sel_b ? b_we        : a_we;
  wire [3:0]  m_sel       = sel_b ? b_sel       : a_sel;
  wire [31:0] m_adr       = sel_b ? b_adr       : a_adr;
  wire [31:0] m_dat       = sel_b ? b_dat       : a_dat;
  wire        m_cmd_ready = sel_b ? b_cmd_ready : a_cmd_ready;
  wire        m_rsp_valid = sel_b ? b_rsp_valid : a_rsp_valid;
  wire        m_rsp_err   = sel_b ? b_rsp_err   : a_rsp_err;
  wire [63:0] m_cipher    = sel_b ? b_cipher    : a_cipher;
  wire        m_busy      = sel_b ? b_busy      : a_busy;

  // slave model: registered ack, CONTROL_0 reports done from the Nth poll on
  int          polls = 0;
  int          poll_base = 0;
  int          done_poll = 1;
  logic [31:0] noack_adr = 32'hFFFF_FFFF;
  logic [31:0] cmos0 = 32'h0, cmos1 = 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      s_ack <= 1'b0;
      s_dat <= 32'h0;
    end else begin
      s_ack <= 1'b0;
      if (m_cyc && m_stb && !s_ack && m_adr != noack_adr) begin
        s_ack <= 1'b1;
        if (!m_we && m_adr == BASE + 32'd24) begin
          polls <= polls + 1;
          s_dat <= ($urandom & ~32'h100) |
                   ((polls - poll_base + 1 >= done_poll) ? 32'h100 : 32'h0);
        end else if (!m_we && m_adr == BASE + 32'd16) s_dat <= cmos0;
        else if (!m_we && m_adr == BASE + 32'd20)     s_dat <= cmos1;
        else                                          s_dat <= $urandom;
      end
    end
  end

  // bus monitor: one record per transfer, length = cycles stb was high
  logic [31:0] q_adr[$];
  logic [31:0] q_dat[$];
  bit          q_we[$];
  int          q_len[$];
  int          cur_len = 0;
  bit          stb_prev = 1'b0;
  int          bus_viol = 0;

  always @(negedge clk) begin
    if (m_stb && !stb_prev) begin
      q_adr.push_back(m_adr);
      q_dat.push_back(m_dat);
      q_we.push_back(m_we);
      cur_len = 0;
    end
    if (m_stb) cur_len++;
    if (!m_stb && stb_prev) q_len.push_back(cur_len);
    if (m_cyc != m_stb) bus_viol++;
    if (m_sel != (m_stb ? 4'hF : 4'h0)) bus_viol++;
    if (!m_we && m_dat != 32'h0) bus_viol++;
    if (m_we && !m_stb) bus_viol++;
    stb_prev = m_stb;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // expected transfer list built from the register map
  logic [31:0] e_adr[$];
  logic [31:0] e_dat[$];
  bit          e_we[$];
  int          e_len[$];
  bit          ex_stop, ex_timed;
  int          ex_nack, ex_noack;

  function automatic void push_exp(input int off, input bit we, input logic [31:0] dat);
    if (ex_stop) return;
    e_adr.push_back(BASE + 32'(off));
    e_we.push_back(we);
    e_dat.push_back(we ? dat : 32'h0);
    if (off == ex_noack) begin
      e_len.push_back(T);
      ex_stop  = 1'b1;
      ex_timed = 1'b1;
    end else begin
      e_len.push_back(2);
      ex_nack++;
    end
  endfunction

  task automatic run_cmd(input bit use_b, input logic [79:0] key, input logic [63:0] plain,
                         input logic [31:0] o0, input logic [31:0] o1,
                         input int dpoll, input int noack_off, input int stall);
    int pmax, npoll, exp_lat, lat, ia, il, vb;
    bit exp_err;
    logic [63:0] exp_cip, held;
    sel_b     = use_b;
    cmos0     = o0;
    cmos1     = o1;
    done_poll = dpoll;
    poll_base = polls;
    noack_adr = (noack_off < 0) ? 32'hFFFF_FFFF : BASE + 32'(noack_off);

    pmax = use_b ? 3 : 255;
    e_adr.delete(); e_dat.delete(); e_we.delete(); e_len.delete();
    ex_stop = 1'b0; ex_timed = 1'b0; ex_nack = 0; ex_noack = noack_off;
    push_exp(0,  1'b1, key[31:0]);
    push_exp(4,  1'b1, key[63:32]);
    push_exp(8,  1'b1, plain[31:0]);
    push_exp(12, 1'b1, plain[63:32]);
    push_exp(24, 1'b1, {key[79:64], 15'b0, 1'b1});
    npoll = (dpoll <= pmax) ? dpoll : pmax;
    for (int i = 0; i < npoll; i++) push_exp(24, 1'b0, 32'h0);
    if (dpoll <= pmax) begin
      push_exp(16, 1'b0, 32'h0);
      push_exp(20, 1'b0, 32'h0);
    end
    exp_err = ex_timed || (dpoll > pmax);
    exp_cip = exp_err ? 64'h0 : {o1, o0};
    exp_lat = 3 * ex_nack + (ex_timed ? T + 1 : 0) + 1;

    ia = q_adr.size();
    il = q_len.size();
    vb = bus_viol;
    chk("cmd_ready_idle", 64'(m_cmd_ready), 64'd1);
    cmd_key   = key;
    cmd_plain = plain;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!m_rsp_valid && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("rsp_err", 64'(m_rsp_err), 64'(exp_err));
    chk("rsp_cipher", m_cipher, exp_cip);
    chk("busy_resp", 64'(m_busy), 64'd1);
    held = m_cipher;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(m_rsp_valid), 64'd1);
      chk("stall_cipher", m_cipher, held);
      chk("stall_cmd_ready", 64'(m_cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("valid_after_hs", 64'(m_rsp_valid), 64'd0);
    chk("ready_after_hs", 64'(m_cmd_ready), 64'd1);
    repeat (3) @(negedge clk);

    chk("xfer_count", 64'(q_adr.size() - ia), 64'(e_adr.size()));
    chk("len_count", 64'(q_len.size() - il), 64'(e_len.size()));
    for (int i = 0; i < e_adr.size() && ia + i < q_adr.size(); i++) begin
      chk("xfer_adr", {32'h0, q_adr[ia+i]}, {32'h0, e_adr[i]});
      chk("xfer_we", 64'(q_we[ia+i]), 64'(e_we[i]));
      chk("xfer_dat", {32'h0, q_dat[ia+i]}, {32'h0, e_dat[i]});
      if (il + i < q_len.size()) chk("xfer_len", 64'(q_len[il+i]), 64'(e_len[i]));
    end
    chk("bus_rules", 64'(bus_viol - vb), 64'd0);
  endtask

  task automatic reset_mid_pl0();
    int n;
    sel_b     = 1'b0;
    done_poll = 1;
    poll_base = polls;
    noack_adr = 32'hFFFF_FFFF;
    cmd_key   = {$urandom, $urandom, $urandom};
    cmd_plain = {$urandom, $urandom};
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!(m_stb && m_adr == BASE + 32'd8) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_pl0_req", 64'(m_stb && m_adr == BASE + 32'd8), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cyc", 64'(m_cyc), 64'd0);
    chk("rst_stb", 64'(m_stb), 64'd0);
    chk("rst_we", 64'(m_we), 64'd0);
    chk("rst_adr", {32'h0, m_adr}, 64'd0);
    chk("rst_sel", 64'(m_sel), 64'd0);
    chk("rst_cmd_ready", 64'(m_cmd_ready), 64'd1);
    chk("rst_busy", 64'(m_busy), 64'd0);
    chk("rst_rsp_valid", 64'(m_rsp_valid), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int off;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_key   = '0;
    cmd_plain = '0;
    rsp_ready = 1'b0;
    sel_b     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_cyc", 64'(a_cyc), 64'd0);
    chk("reset_stb", 64'(a_stb), 64'd0);
    chk("reset_we", 64'(a_we), 64'd0);
    chk("reset_sel", 64'(a_sel), 64'd0);
    chk("reset_adr", {32'h0, a_adr}, 64'd0);
    chk("reset_dat", {32'h0, a_dat}, 64'd0);
    chk("reset_cmd_ready", 64'(a_cmd_ready), 64'd1);
    chk("reset_rsp_valid", 64'(a_rsp_valid), 64'd0);
    chk("reset_rsp_err", 64'(a_rsp_err), 64'd0);
    chk("reset_cipher", a_cipher, 64'd0);
    chk("reset_busy", 64'(a_busy), 64'd0);
    chk("reset_b_cmd_ready", 64'(b_cmd_ready), 64'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // best case: zero key/plain, done on first poll
    run_cmd(1'b0, 80'h0, 64'h0, 32'h7B228445, 32'h5579C138, 1, -1, 0);
    // all-ones key/plain
    run_cmd(1'b0, {80{1'b1}}, {64{1'b1}}, $urandom, $urandom, 1, -1, 0);
    // done on 4th poll
    run_cmd(1'b0, {$urandom, $urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom, 4, -1, 0);
    // poll limit of 3 exhausted
    run_cmd(1'b1, {$urandom, $urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom, 4, -1, 0);
    // poll limit of 3, done exactly on the last allowed poll
    run_cmd(1'b1, {$urandom, $urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom, 3, -1, 0);
    // KEY_1 write never acked
    run_cmd(1'b0, {$urandom, $urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom, 1, 4, 0);
    // response back-pressure
    run_cmd(1'b0, {$urandom, $urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom, 2, -1, 10);
    // reset during PLAIN_0 REQ, then a clean command
    reset_mid_pl0();
    run_cmd(1'b0, {$urandom, $urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom, 1, -1, 0);

    for (int k = 0; k < 24; k++) begin
      off = ($urandom_range(0, 4) == 0) ? 4 * $urandom_range(0, 5) : -1;
      run_cmd(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom}, {$urandom, $urandom},
              $urandom, $urandom, $urandom_range(1, 5), off, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/present_wb_initiator.md
# present_wb_initiator

Wishbone classic initiator that drives the PRESENT-80 register slave from the other end of the bus. It accepts one encryption command (80-bit key, 64-bit plaintext) on a valid/ready port and writes KEY_0/1, PLAIN_0/1 and CONTROL_0. It then polls CONTROL_0 for completion, reads CMOS_OUT_0/1, and returns the 64-bit ciphertext on a valid/ready response port. It sits between a local command source (LA- or test-harness-driven) and the user-area Wishbone slave.

## Interface
- BASE_ADDRESS, 32'h03000000, slave base; registers at +0 KEY_0, +4 KEY_1, +8 PLAIN_0, +12 PLAIN_1, +16 CMOS_OUT_0, +20 CMOS_OUT_1, +24 CONTROL_0
- ACK_TIMEOUT, 16, cycles a transfer waits for ack before abort (≥2)
- POLL_MAX, 255, maximum CONTROL_0 reads while waiting for done (≥1)
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset; **one clock; reset is synchronous and active-high**
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake
- cmd_key_i  in  80  key; cmd_plain_i  in  64  plaintext
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake
- rsp_cipher_o  out  64  {CMOS_OUT_1, CMOS_OUT_0}; rsp_err_o  out  1  timeout flag
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  bus control
- wbm_sel_o  out  4  always 4'hF during a transfer
- wbm_adr_o, wbm_dat_o  out  32  address, write data; wbm_dat_i  in  32  read data; wbm_ack_i  in  1
- busy_o  out  1  high in every state except IDLE

## Operation
- Word map:
  - KEY_0 = key[31:0], KEY_1 = key[63:32]
  - PLAIN_0 = plain[31:0], PLAIN_1 = plain[63:32]
  - CONTROL_0 write = {key[79:64], 15'b0, 1'b1}; bit0 is start
  - CONTROL_0 read bit8 = done
- Command and key/plain are latched on cmd_valid_i && cmd_ready_o. cmd_ready_o = (state == IDLE).
- States:
  - IDLE → W_KEY0 → W_KEY1 → W_PL0 → W_PL1 → W_CTRL → R_POLL → R_OUT0 → R_OUT1 → RESP → IDLE.
  - Each bus state has two phases, REQ (cyc=stb=1) then GAP (cyc=stb=0, one cycle), before the next state.
- R_POLL: on ack with wbm_dat_i[8] = 1 → R_OUT0. Otherwise increment the poll counter and repeat. When the counter reaches POLL_MAX → RESP with err.
- Ack timeout: a per-transfer counter starts at the REQ cycle and clears on ack. When it reaches ACK_TIMEOUT, cyc/stb drop, rsp_err_o = 1, and the FSM goes to RESP with rsp_cipher_o = 0.
- Read data is captured on the ack cycle: R_OUT0 → cipher[31:0], R_OUT1 → cipher[63:32].
- RESP: rsp_valid_o = 1 and stays held, with cipher/err stable, until rsp_ready_i. Then → IDLE.
- wbm_we_o = 1 only in the W_* REQ phases. wbm_dat_o = 0 whenever we = 0.
- Counters saturate and never wrap. Ack is ignored outside REQ.

## Timing
- Reset values: cyc, stb, we, adr, dat, sel = 0; cmd_ready_o = 1; rsp_valid_o = 0; rsp_err_o = 0; rsp_cipher_o = 0; busy_o = 0; state IDLE; counters 0.
- Reset mid-transfer: all outputs reach their reset values at the first clock edge with wb_rst_i high; the latched command is discarded.
- First REQ cycle is the cycle after command acceptance.
- Against the slave's registered ack (ack one cycle after REQ), each transfer takes 3 cycles: REQ, ACK, GAP.
- Best case, command accept to rsp_valid_o = 8 transfers × 3 + 1 = 25 cycles, with done seen on the first poll.
- All bus outputs are registered. No combinational path from wbm_ack_i to wbm_stb_o.
- A new command is accepted no earlier than the cycle after the RESP handshake.

## Structure
- Shared package present_wb_pkg:
  - register offsets (0/4/8/12/16/20/24)
  - CONTROL_0 bit positions (START = 0, DONE = 8, KEYHI = 31:16)
  - the state enum
- One natural sub-module, present_wb_xfer: single Wishbone transfer engine handling REQ/GAP, the ack timeout and read-data capture, driven by the sequencer FSM.

## Test plan
- Responsive slave model, key = 0, plain = 0, done on first poll, CMOS_OUT = 7B228445/5579C138 → 8 transfers at offsets 0,4,8,12,24,24,16,20; rsp_cipher_o = 64'h5579C1387B228445; err = 0; rsp_valid_o in cycle 25.
- key = 80'hFFFF_FFFFFFFF_FFFFFFFF, plain = 64'hFFFFFFFF_FFFFFFFF → CONTROL_0 write data 32'hFFFF0001; KEY_0/1 and PLAIN_0/1 writes = 32'hFFFFFFFF.
- Done asserted on the 4th poll → exactly 4 CONTROL_0 reads, then OUT reads. With POLL_MAX = 3 → rsp_err_o = 1, cipher = 0, no OUT reads.
- Slave never acks the KEY_1 write → cyc drops ACK_TIMEOUT cycles after REQ; rsp_err_o = 1; no further transfers.
- rsp_ready_i held low 10 cycles → rsp_valid_o and data stable; cmd_ready_o = 0 until the handshake completes.
- wb_rst_i pulsed during the W_PL0 REQ → next edge: cyc = stb = 0, cmd_ready_o = 1; a fresh command then completes normally.
